// File: rtl/srl_fifo_read_ctrl_if.sv
// Producer, consumer and SRL-storage signals of the SRL FIFO read controller.
// The slave modport is the controller's view; master is the surrounding environment's view.
interface srl_fifo_read_ctrl_if #(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 1
);
    logic                  if_write;
    logic                  if_full_n;
    logic [DATA_WIDTH-1:0] if_din;
    logic                  if_empty_n;
    logic                  if_read;
    logic [DATA_WIDTH-1:0] if_dout;
    logic                  srl_we;
    logic [ADDR_WIDTH-1:0] srl_addr;
    logic [DATA_WIDTH-1:0] srl_dout;

    modport slave (
        input  if_write,
        input  if_din,
        input  if_read,
        input  srl_dout,
        output if_full_n,
        output if_empty_n,
        output if_dout,
        output srl_we,
        output srl_addr
    );

    modport master (
        output if_write,
        output if_din,
        output if_read,
        output srl_dout,
        input  if_full_n,
        input  if_empty_n,
        input  if_dout,
        input  srl_we,
        input  srl_addr
    );
endinterface

// File: rtl/srl_fifo_read_ctrl.sv
// Purpose: occupancy/address control for an SRL FIFO plus a registered FWFT output stage.
// Latency: write to if_empty_n is 2 cycles, or 1 cycle into an empty FIFO when SRL_FIFO_BYPASS_EN is defined.
// Backpressure: if_full_n drops at DEPTH SRL entries (a same-cycle pop frees nothing); output holds until if_read.
module srl_fifo_read_ctrl #(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 1,
    parameter int DEPTH      = 2
) (
    input  logic                clk,
    input  logic                reset,
    srl_fifo_read_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [CNT_W-1:0]      cnt_q,      cnt_d;
    logic                  out_vld_q,  out_vld_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

    logic                  full_n;
    logic                  wr_ok;
    logic                  rd_ok;
    logic                  byp;
    logic                  pop;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;

    always_comb begin
        full_n = (cnt_q != CNT_W'(DEPTH));
        wr_ok  = bus.if_write & full_n;
        rd_ok  = bus.if_read & out_vld_q;
`ifdef SRL_FIFO_BYPASS_EN
        // An empty SRL with a free output stage lets the write land directly in the output register.
        byp    = wr_ok & (cnt_q == '0) & (~out_vld_q | rd_ok);
`else
        byp    = 1'b0;
`endif
        we     = wr_ok & ~byp;
        pop    = (cnt_q != '0) & (~out_vld_q | rd_ok);
        // Oldest entry sits at cnt-1; a same-edge shift keeps the next-oldest at that same index.
        addr   = (cnt_q != '0) ? ADDR_WIDTH'(cnt_q - CNT_W'(1)) : '0;
    end

    always_comb begin
        cnt_d      = cnt_q;
        out_vld_d  = out_vld_q;
        out_data_d = out_data_q;

        if (we && !pop) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (pop && !we) begin
            cnt_d = cnt_q - CNT_W'(1);
        end

        if (pop) begin
            out_vld_d  = 1'b1;
            out_data_d = bus.srl_dout;
        end else if (byp) begin
            out_vld_d  = 1'b1;
            out_data_d = bus.if_din;
        end else if (rd_ok) begin
            out_vld_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q      <= '0;
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
        end else begin
            cnt_q      <= cnt_d;
            out_vld_q  <= out_vld_d;
            out_data_q <= out_data_d;
        end
    end

`ifndef SRL_FIFO_BYPASS_EN
    logic unused_din;
    assign unused_din = ^bus.if_din;
`endif

    assign bus.if_full_n  = full_n;
    assign bus.srl_we     = we;
    assign bus.srl_addr   = addr;
    assign bus.if_empty_n = out_vld_q;
    assign bus.if_dout    = out_data_q;
endmodule
